dot11_tx_plcp_framer: RTL and testbench

- Transmit-side counterpart of the receiver's SIGNAL decode and descramble stages. It builds the legacy 802.11a/g PLCP bit stream for one frame, in this order:
  - the 24-bit SIGNAL field, unscrambled;
  - the DATA field: SERVICE, PSDU, tail and pad, scrambled.
- It sits between the MAC byte FIFO and the convolutional encoder, and emits one bit per accepted handshake, with OFDM-symbol boundary markers.

---
 rtl/dot11_tx_pkg.sv | 41 ++++
 rtl/dot11_tx_scrambler.sv | 29 ++
 rtl/dot11_tx_plcp_framer.sv | 178 +++++++++++++++++
 tb/tb_dot11_tx_plcp_framer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot11_tx_pkg.sv
// Shared definitions for the 802.11a/g transmit PLCP framer: rate codes,
// framer states and the rate-to-N_DBPS lookup.
package dot11_tx_pkg;

  localparam logic [3:0] RATE_6M  = 4'b1101;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b0101;
  localparam logic [3:0] RATE_18M = 4'b0111;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1011;
  localparam logic [3:0] RATE_48M = 4'b0001;
  localparam logic [3:0] RATE_54M = 4'b0011;

  localparam int SERVICE_BITS = 16;
  localparam int TAIL_BITS    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGNAL,
    S_SERVICE,
    S_PSDU,
    S_TAIL,
    S_PAD
  } state_t;

  // Zero marks an unsupported code, which doubles as the validity test.
  function automatic logic [8:0] rate_to_ndbps(input logic [3:0] rate);
    case (rate)
      RATE_6M:  return 9'd24;
      RATE_9M:  return 9'd36;
      RATE_12M: return 9'd48;
      RATE_18M: return 9'd72;
      RATE_24M: return 9'd96;
      RATE_36M: return 9'd144;
      RATE_48M: return 9'd192;
      RATE_54M: return 9'd216;
      default:  return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/dot11_tx_scrambler.sv
// Frame-synchronous scrambler, x^7 + x^4 + 1, with seed load and
// per-bit advance.
module dot11_tx_scrambler (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [6:0] i_seed,
  input  logic       i_advance,
  input  logic       i_data,
  output logic       o_data
);

  logic [6:0] r_state;
  logic       w_fb;

  assign w_fb   = r_state[6] ^ r_state[3];
  assign o_data = i_data ^ w_fb;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= 7'd0;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_advance) begin
      r_state <= {r_state[5:0], w_fb};
    end
  end

endmodule

// File: rtl/dot11_tx_plcp_framer.sv
// Legacy OFDM PLCP framer: SIGNAL field, then scrambled SERVICE/PSDU/tail/pad,
// one bit per handshake with OFDM symbol markers.
module dot11_tx_plcp_framer
  import dot11_tx_pkg::*;
#(
  parameter int PSDU_LEN_WIDTH = 12,
  parameter int NSYM_WIDTH     = 12
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [3:0]                i_rate,
  input  logic [PSDU_LEN_WIDTH-1:0] i_psdu_len,
  input  logic [6:0]                i_scram_seed,
  output logic                      o_param_err,
  output logic                      o_busy,
  input  logic [7:0]                i_byte_in,
  input  logic                      i_byte_in_valid,
  output logic                      o_byte_in_ready,
  output logic                      o_bit_out,
  output logic                      o_bit_out_valid,
  input  logic                      i_bit_out_ready,
  output logic                      o_bit_is_signal,
  output logic                      o_sym_last,
  output logic                      o_frame_done,
  output logic [NSYM_WIDTH-1:0]     o_n_ofdm_sym
);

  state_t                    r_state, r_state_next;
  logic [3:0]                r_rate;
  logic [PSDU_LEN_WIDTH-1:0] r_len, r_fetch_left, r_send_left;
  logic [8:0]                r_ndbps, r_dcnt;
  logic [4:0]                r_sig_cnt;
  logic [3:0]                r_svc_cnt;
  logic [2:0]                r_tail_cnt, r_bit_idx;
  logic [7:0]                r_byte;
  logic                      r_byte_full, r_param_err, r_done;
  logic [NSYM_WIDTH-1:0]     r_nsym;

  logic [8:0]  w_ndbps_in;
  logic        w_start_ok, w_start_bad, w_xfer, w_data_state, w_sym_end;
  logic        w_consume, w_fetch_ok, w_raw_bit, w_scr_bit, w_frame_end;
  logic [23:0] w_signal;

  assign w_ndbps_in  = rate_to_ndbps(i_rate);
  assign w_start_ok  = i_start && (r_state == S_IDLE) && (w_ndbps_in != 9'd0) &&
                       (i_psdu_len != '0) && (i_scram_seed != 7'd0);
  assign w_start_bad = i_start && (r_state == S_IDLE) && !w_start_ok;

  // Index i of w_signal is the i-th transmitted SIGNAL bit.
  assign w_signal[3:0]   = {r_rate[0], r_rate[1], r_rate[2], r_rate[3]};
  assign w_signal[4]     = 1'b0;
  assign w_signal[16:5]  = 12'(r_len);
  assign w_signal[17]    = ^w_signal[16:0];
  assign w_signal[23:18] = 6'd0;

  assign w_xfer       = o_bit_out_valid && i_bit_out_ready;
  assign w_data_state = (r_state == S_SERVICE) || (r_state == S_PSDU) ||
                        (r_state == S_TAIL) || (r_state == S_PAD);
  assign w_sym_end    = (r_dcnt == r_ndbps - 9'd1);
  assign w_consume    = w_xfer && (r_state == S_PSDU) && (r_bit_idx == 3'd7);
  assign w_fetch_ok   = ((r_state == S_SERVICE) || (r_state == S_PSDU)) &&
                        (r_fetch_left != '0);
  // Refill in the same cycle the last bit of the held byte leaves: no bubble.
  assign o_byte_in_ready = w_fetch_ok && i_byte_in_valid && (!r_byte_full || w_consume);
  assign w_raw_bit    = (r_state == S_PSDU) ? r_byte[r_bit_idx] : 1'b0;
  assign w_frame_end  = w_xfer && w_sym_end &&
                        (((r_state == S_TAIL) && (r_tail_cnt == 3'(TAIL_BITS - 1))) ||
                         (r_state == S_PAD));

  dot11_tx_scrambler u_scrambler (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_load    (w_start_ok),
    .i_seed    (i_scram_seed),
    .i_advance (w_xfer && w_data_state),
    .i_data    (w_raw_bit),
    .o_data    (w_scr_bit)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= r_state_next;
  end

  always_comb begin
    r_state_next    = r_state;
    o_bit_out       = 1'b0;
    o_bit_out_valid = 1'b0;
    o_bit_is_signal = 1'b0;
    o_sym_last      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_ok) r_state_next = S_SIGNAL;
      S_SIGNAL: begin
        o_bit_out_valid = 1'b1;
        o_bit_out       = w_signal[r_sig_cnt];
        o_bit_is_signal = 1'b1;
        o_sym_last      = (r_sig_cnt == 5'd23);
        if (w_xfer && r_sig_cnt == 5'd23) r_state_next = S_SERVICE;
      end
      S_SERVICE: begin
        o_bit_out_valid = 1'b1;
        o_bit_out       = w_scr_bit;
        o_sym_last      = w_sym_end;
        if (w_xfer && r_svc_cnt == 4'(SERVICE_BITS - 1)) r_state_next = S_PSDU;
      end
      S_PSDU: begin
        o_bit_out_valid = r_byte_full;
        o_bit_out       = w_scr_bit;
        o_sym_last      = r_byte_full && w_sym_end;
        if (w_consume && r_send_left == PSDU_LEN_WIDTH'(1)) r_state_next = S_TAIL;
      end
      S_TAIL: begin
        o_bit_out_valid = 1'b1;
        o_sym_last      = w_sym_end;
        if (w_xfer && r_tail_cnt == 3'(TAIL_BITS - 1))
          r_state_next = w_sym_end ? S_IDLE : S_PAD;
      end
      S_PAD: begin
        o_bit_out_valid = 1'b1;
        o_bit_out       = w_scr_bit;
        o_sym_last      = w_sym_end;
        if (w_xfer && w_sym_end) r_state_next = S_IDLE;
      end
      default: r_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rate <= '0; r_len <= '0; r_ndbps <= '0; r_dcnt <= '0; r_nsym <= '0;
      r_sig_cnt <= '0; r_svc_cnt <= '0; r_tail_cnt <= '0; r_bit_idx <= '0;
      r_fetch_left <= '0; r_send_left <= '0; r_byte <= '0; r_byte_full <= 1'b0;
      r_param_err <= 1'b0; r_done <= 1'b0;
    end else begin
      r_param_err <= w_start_bad;
      r_done      <= w_frame_end;
      if (w_start_ok) begin
        r_rate <= i_rate; r_len <= i_psdu_len; r_ndbps <= w_ndbps_in;
        r_dcnt <= '0; r_nsym <= '0; r_sig_cnt <= '0; r_svc_cnt <= '0;
        r_tail_cnt <= '0; r_bit_idx <= '0; r_byte_full <= 1'b0;
        r_fetch_left <= i_psdu_len; r_send_left <= i_psdu_len;
      end else begin
        if (w_xfer) begin
          case (r_state)
            S_SIGNAL:  r_sig_cnt  <= r_sig_cnt + 5'd1;
            S_SERVICE: r_svc_cnt  <= r_svc_cnt + 4'd1;
            S_PSDU:    r_bit_idx  <= r_bit_idx + 3'd1;
            S_TAIL:    r_tail_cnt <= r_tail_cnt + 3'd1;
            default:   ;
          endcase
        end
        if (w_xfer && w_data_state) begin
          if (w_sym_end) begin
            r_dcnt <= '0;
            r_nsym <= r_nsym + NSYM_WIDTH'(1);
          end else begin
            r_dcnt <= r_dcnt + 9'd1;
          end
        end
        if (o_byte_in_ready) begin
          r_byte       <= i_byte_in;
          r_byte_full  <= 1'b1;
          r_fetch_left <= r_fetch_left - PSDU_LEN_WIDTH'(1);
        end else if (w_consume) begin
          r_byte_full  <= 1'b0;
        end
        if (w_consume) r_send_left <= r_send_left - PSDU_LEN_WIDTH'(1);
      end
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_param_err  = r_param_err;
  assign o_frame_done = r_done;
  assign o_n_ofdm_sym = r_nsym;

endmodule

// File: tb/tb_dot11_tx_plcp_framer.sv
// Scoreboard bench for the PLCP framer: a reference model queues every
// expected bit with its flags, and the monitor pops one per handshake.
module tb_dot11_tx_plcp_framer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rate = 4'd0;
  logic [11:0] psdu_len = 12'd0;
  logic [6:0]  scram_seed = 7'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_in_valid = 1'b0;
  logic        bit_out_ready = 1'b0;
  logic        param_err, busy, byte_in_ready, bit_out, bit_out_valid;
  logic        bit_is_signal, sym_last, frame_done;
  logic [11:0] n_ofdm_sym;

  always #5 clk = ~clk;

  dot11_tx_plcp_framer #(.PSDU_LEN_WIDTH(12), .NSYM_WIDTH(12)) dut (
    .i_clock(clk), .i_reset(reset), .i_start(start), .i_rate(rate),
    .i_psdu_len(psdu_len), .i_scram_seed(scram_seed), .o_param_err(param_err),
    .o_busy(busy), .i_byte_in(byte_in), .i_byte_in_valid(byte_in_valid),
    .o_byte_in_ready(byte_in_ready), .o_bit_out(bit_out),
    .o_bit_out_valid(bit_out_valid), .i_bit_out_ready(bit_out_ready),
    .o_bit_is_signal(bit_is_signal), .o_sym_last(sym_last),
    .o_frame_done(frame_done), .o_n_ofdm_sym(n_ofdm_sym)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  logic [7:0] byte_q[$];
  logic [7:0] frame_bytes[$];
  logic       cap_q[$];
  logic       ref_q[$];
  bit         stall = 1'b0;
  bit         abort = 1'b0;
  int         n_sig, n_dsym, done_cnt, exp_nsym;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor and input driver: sample at negedge, drive just after posedge.
  initial begin
    logic [2:0] obs, e;
    bit         byte_taken;
    forever begin
      @(negedge clk);
      if (!abort && bit_out_valid && bit_out_ready) begin
        obs = {bit_out, bit_is_signal, sym_last};
        if (exp_q.size() == 0) chk("extra_bit", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("bit%0d", cap_q.size()), int'(obs), int'(e));
        end
        cap_q.push_back(bit_out);
        if (bit_is_signal) n_sig++;
        else if (sym_last) n_dsym++;
      end
      byte_taken = byte_in_valid && byte_in_ready;
      if (frame_done) done_cnt++;
      @(posedge clk);
      #1;
      if (byte_taken && byte_q.size() > 0) void'(byte_q.pop_front());
      byte_in_valid = (byte_q.size() > 0) && (!stall || $urandom_range(0, 3) != 0);
      byte_in       = (byte_q.size() > 0) ? byte_q[0] : 8'd0;
      bit_out_ready = !stall || ($urandom_range(0, 2) != 0);
    end
  end

  function automatic int ndbps_of(input logic [3:0] r);
    case (r)
      4'b1101: return 24;  4'b1111: return 36;  4'b0101: return 48;
      4'b0111: return 72;  4'b1001: return 96;  4'b1011: return 144;
      4'b0001: return 192; 4'b0011: return 216;
      default: return 0;
    endcase
  endfunction

  task automatic build_model(input logic [3:0] r, input int len, input logic [6:0] sd);
    logic [23:0] sig;
    logic [6:0]  s;
    logic [7:0]  b;
    logic        raw, fb, o;
    int          nd, total;
    sig = '0;
    for (int i = 0; i < 4; i++) sig[i] = r[3-i];
    for (int i = 0; i < 12; i++) sig[5+i] = (len >> i) & 1;
    sig[17] = ^sig[16:0];
    for (int i = 0; i < 24; i++) exp_q.push_back({sig[i], 1'b1, i == 23});
    nd       = ndbps_of(r);
    exp_nsym = (22 + 8 * len + nd - 1) / nd;
    total    = exp_nsym * nd;
    s = sd;
    for (int k = 0; k < total; k++) begin
      raw = 1'b0;
      if (k >= 16 && k < 16 + 8 * len) begin
        b   = frame_bytes[(k - 16) / 8];
        raw = b[(k - 16) % 8];
      end
      fb = s[6] ^ s[3];
      s  = {s[5:0], fb};
      o  = (k >= 16 + 8 * len && k < 22 + 8 * len) ? 1'b0 : (raw ^ fb);
      exp_q.push_back({o, 1'b0, (k % nd) == nd - 1});
    end
  endtask

  task automatic start_frame(input logic [3:0] r, input int len, input logic [6:0] sd,
                             input bit st);
    exp_q.delete();
    cap_q.delete();
    build_model(r, len, sd);
    n_sig = 0; n_dsym = 0; done_cnt = 0; stall = st;
    byte_q = frame_bytes;
    @(posedge clk); #1;
    rate = r; psdu_len = 12'(len); scram_seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("first_sig_valid", {busy, bit_out_valid, bit_is_signal}, 3'b111);
  endtask

  task automatic finish_frame(input string name);
    int cycles = 0;
    while (done_cnt == 0 && cycles < 30000) begin
      @(negedge clk);
      cycles++;
    end
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_nsym"}, n_ofdm_sym, exp_nsym);
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_sig_cnt"}, n_sig, 24);
    chk({name, "_data_sym_last"}, n_dsym, exp_nsym);
    repeat (4) @(negedge clk);
    chk({name, "_single_done"}, done_cnt, 1);
    chk({name, "_nsym_held"}, n_ofdm_sym, exp_nsym);
    stall = 1'b0;
  endtask

  task automatic fill_bytes(input int len);
    frame_bytes.delete();
    for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
  endtask

  task automatic bad_start(input string name, input logic [3:0] r, input int len,
                           input logic [6:0] sd);
    @(posedge clk); #1;
    rate = r; psdu_len = 12'(len); scram_seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, "_param_err"}, param_err, 1);
    chk({name, "_busy"}, busy, 0);
    @(negedge clk);
    chk({name, "_err_pulse"}, param_err, 0);
    chk({name, "_still_idle"}, {busy, bit_out_valid}, 0);
  endtask

  initial begin
    logic [23:0] sig_v;
    logic [15:0] svc_v;
    int          mism, guard;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {param_err, busy, byte_in_ready, bit_out_valid, bit_is_signal,
                       sym_last, frame_done, bit_out}, 0);
    chk("reset_nsym", n_ofdm_sym, 0);

    // 6M, 100 bytes, all-ones seed; also keep the stream for the stall rerun.
    fill_bytes(100);
    start_frame(4'b1101, 100, 7'h7F, 1'b0);
    finish_frame("6m_100");
    sig_v = '0; svc_v = '0;
    for (int i = 0; i < 24; i++) sig_v = {sig_v[22:0], cap_q[i]};
    for (int i = 0; i < 16; i++) svc_v = {svc_v[14:0], cap_q[24+i]};
    chk("signal_field", int'(sig_v), int'(24'b110100010011000000000000));
    chk("service_bits", int'(svc_v), int'(16'b0000111011110010));
    chk("6m_100_bits", cap_q.size(), 24 + 840);
    ref_q = cap_q;

    start_frame(4'b1101, 100, 7'h7F, 1'b1);
    finish_frame("6m_100_stall");
    mism = 0;
    for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++)
      if (cap_q[i] !== ref_q[i]) mism++;
    chk("stall_len", cap_q.size(), ref_q.size());
    chk("stall_same", mism, 0);

    fill_bytes(1);
    start_frame(4'b0011, 1, 7'h35, 1'b0);
    finish_frame("54m_1");
    chk("54m_1_bits", cap_q.size(), 24 + 216);

    fill_bytes(37);
    start_frame(4'b1011, 37, 7'h01, 1'b1);
    finish_frame("36m_37_stall");

    bad_start("bad_rate", 4'b0000, 10, 7'h55);
    bad_start("bad_len", 4'b1101, 0, 7'h55);
    bad_start("bad_seed", 4'b1101, 10, 7'h00);

    // Abandon a frame part way through the PSDU.
    fill_bytes(50);
    start_frame(4'b0101, 50, 7'h4A, 1'b0);
    guard = 0;
    while (cap_q.size() < 24 + 16 + 60 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reach_psdu", int'(cap_q.size() >= 100), 1);
    abort = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    byte_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("abort_idle", {busy, bit_out_valid, byte_in_ready}, 0);
    chk("abort_nsym", n_ofdm_sym, 0);
    repeat (40) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    abort = 1'b0;

    fill_bytes(20);
    start_frame(4'b1001, 20, 7'h6C, 1'b0);
    finish_frame("24m_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
